// File: rtl/tcdm_master_shim_if.sv
// Bundle of the upstream request/response handshakes, the interconnect
// initiator port and the status flags of tcdm_master_shim. Signal suffixes
// are from the shim's point of view.
interface tcdm_master_shim_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8
) ();

  // upstream request
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [AddrWidth-1:0] in_addr_i;
  logic                 in_wen_i;
  logic [DataWidth-1:0] in_wdata_i;
  logic [BeWidth-1:0]   in_be_i;
  // upstream load response
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DataWidth-1:0] rsp_rdata_o;
  // interconnect initiator port
  logic                 tcdm_req_o;
  logic                 tcdm_gnt_i;
  logic [AddrWidth-1:0] tcdm_add_o;
  logic                 tcdm_wen_o;
  logic [DataWidth-1:0] tcdm_wdata_o;
  logic [BeWidth-1:0]   tcdm_be_o;
  logic                 tcdm_vld_i;
  logic [DataWidth-1:0] tcdm_rdata_i;
  // status
  logic                 idle_o;
  logic                 err_o;

  // The shim itself: masters the interconnect port.
  modport master (
    input  in_valid_i, in_addr_i, in_wen_i, in_wdata_i, in_be_i,
    output in_ready_o,
    output rsp_valid_o, rsp_rdata_o,
    input  rsp_ready_i,
    output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o,
    input  tcdm_gnt_i, tcdm_vld_i, tcdm_rdata_i,
    output idle_o, err_o
  );

  // The environment around the shim (upstream core plus interconnect).
  modport slave (
    output in_valid_i, in_addr_i, in_wen_i, in_wdata_i, in_be_i,
    input  in_ready_o,
    input  rsp_valid_o, rsp_rdata_o,
    output rsp_ready_i,
    input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o,
    output tcdm_gnt_i, tcdm_vld_i, tcdm_rdata_i,
    input  idle_o, err_o
  );

endinterface

// File: rtl/tcdm_master_shim.sv
// TCDM master shim: passes upstream requests straight to one interconnect
// port, tracks outstanding transactions in a tag FIFO and buffers load data
// in a registered response FIFO. Issue is credit-limited so the data FIFO
// can never overflow even when upstream never accepts responses.
module tcdm_master_shim #(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned BeWidth     = DataWidth / 8,
  parameter int unsigned RespDepth   = 4,
  parameter bit          WriteRespOn = 1'b1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  tcdm_master_shim_if.master  bus
);

  localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(RespDepth);

  // tag FIFO: one bit per tracked transaction, 1 = store
  logic [RespDepth-1:0] tag_mem_q;
  logic [PtrW-1:0]      tag_wr_q, tag_rd_q;
  logic [CntW-1:0]      tag_cnt_q;
  // data FIFO: load data waiting for upstream
  logic [DataWidth-1:0] dat_mem_q [RespDepth];
  logic [PtrW-1:0]      dat_wr_q, dat_rd_q;
  logic [CntW-1:0]      dat_cnt_q;
  logic                 err_q;

  logic            tracked;
  logic            credit_ok;
  logic [CntW:0]   outstanding;
  logic            granted;
  logic            tag_push, tag_pop, tag_head;
  logic            dat_push, dat_pop;
  logic            spurious_vld;

  // Credit and FIFO control; a store only consumes credit when it will
  // produce a response that has to be matched against a tag.
  always_comb begin
    tracked      = ~bus.in_wen_i | WriteRespOn;
    outstanding  = {1'b0, tag_cnt_q} + {1'b0, dat_cnt_q};
    credit_ok    = ~tracked | (outstanding < DepthLim);
    granted      = bus.in_valid_i & credit_ok & bus.tcdm_gnt_i;
    tag_push     = granted & tracked;
    spurious_vld = bus.tcdm_vld_i & (tag_cnt_q == '0);
    tag_pop      = bus.tcdm_vld_i & ~spurious_vld;
    tag_head     = tag_mem_q[tag_rd_q];
    dat_push     = tag_pop & ~tag_head;
    dat_pop      = (dat_cnt_q != '0) & bus.rsp_ready_i;
  end

  // Request path is pure pass-through gated by credit.
  assign bus.tcdm_req_o   = bus.in_valid_i & credit_ok;
  assign bus.in_ready_o   = bus.tcdm_gnt_i & credit_ok;
  assign bus.tcdm_add_o   = bus.in_addr_i;
  assign bus.tcdm_wen_o   = bus.in_wen_i;
  assign bus.tcdm_wdata_o = bus.in_wdata_i;
  assign bus.tcdm_be_o    = bus.in_be_i;

  // Response side comes only from registers.
  assign bus.rsp_valid_o = (dat_cnt_q != '0);
  assign bus.rsp_rdata_o = dat_mem_q[dat_rd_q];
  assign bus.idle_o      = (tag_cnt_q == '0) & (dat_cnt_q == '0);
  assign bus.err_o       = err_q;

  // Tag FIFO: record the kind of each tracked grant, retire on each response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_mem_q <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (tag_push) begin
        tag_mem_q[tag_wr_q] <= bus.in_wen_i;
        tag_wr_q            <= tag_wr_q + PtrW'(1);
      end
      if (tag_pop) begin
        tag_rd_q <= tag_rd_q + PtrW'(1);
      end
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + CntW'(1);
        2'b01:   tag_cnt_q <= tag_cnt_q - CntW'(1);
        default: tag_cnt_q <= tag_cnt_q;
      endcase
    end
  end

  // Data FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_wr_q  <= '0;
      dat_rd_q  <= '0;
      dat_cnt_q <= '0;
    end else begin
      if (dat_push) begin
        dat_wr_q <= dat_wr_q + PtrW'(1);
      end
      if (dat_pop) begin
        dat_rd_q <= dat_rd_q + PtrW'(1);
      end
      case ({dat_push, dat_pop})
        2'b10:   dat_cnt_q <= dat_cnt_q + CntW'(1);
        2'b01:   dat_cnt_q <= dat_cnt_q - CntW'(1);
        default: dat_cnt_q <= dat_cnt_q;
      endcase
    end
  end

  // Data FIFO storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk_i) begin
    if (dat_push) begin
      dat_mem_q[dat_wr_q] <= bus.tcdm_rdata_i;
    end
  end

  // Sticky error on a response nobody is waiting for.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (spurious_vld) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcdm_master_shim.sv
// Self-checking bench for tcdm_master_shim: a behavioural interconnect that
// answers every grant one cycle later, and a scoreboard of expected load data.
module tb_tcdm_master_shim;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcdm_master_shim_if #(.AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) ifc ();
  tcdm_master_shim_if #(.AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) ifn ();

  tcdm_master_shim #(.AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
                     .RespDepth(DEPTH), .WriteRespOn(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(ifc));

  tcdm_master_shim #(.AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
                     .RespDepth(DEPTH), .WriteRespOn(1'b0)) u_dut_nw (
    .clk_i(clk), .rst_i(rst), .bus(ifn));

  typedef struct { logic wen; logic [31:0] data; } pend_t;

  int vec_cnt = 0;
  int err_cnt = 0;
  int grant_cnt = 0;
  int rsp_cnt = 0;
  int cyc = 0;
  bit resp_en = 1'b1;
  pend_t pend[$];
  logic [31:0] exp_q[$];

  logic        s_grant, s_wen, s_fire;
  logic [31:0] s_addr, s_data;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hDEADBEAF;
  endfunction

  // negedge snapshot of the handshakes that complete at the next posedge
  initial begin
    s_grant = 1'b0; s_wen = 1'b0; s_fire = 1'b0; s_addr = '0; s_data = '0;
    forever begin
      @(negedge clk);
      s_grant = ifc.tcdm_req_o & ifc.tcdm_gnt_i;
      s_wen   = ifc.tcdm_wen_o;
      s_addr  = ifc.tcdm_add_o;
      s_fire  = ifc.rsp_valid_o & ifc.rsp_ready_i;
      s_data  = ifc.rsp_rdata_o;
    end
  end

  // interconnect model + scoreboard
  initial begin
    pend_t p;
    logic [31:0] e;
    ifc.tcdm_vld_i = 1'b0;
    ifc.tcdm_rdata_i = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (s_grant) begin
        grant_cnt++;
        p.wen = s_wen;
        p.data = s_wen ? (32'hBAD00000 ^ s_addr) : mem_val(s_addr);
        pend.push_back(p);
        if (!s_wen) exp_q.push_back(mem_val(s_addr));
      end
      if (s_fire) begin
        rsp_cnt++;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL rsp_unexpected got=%h want=none", s_data);
        end else begin
          e = exp_q.pop_front();
          if (s_data !== e) begin
            err_cnt++;
            $display("FAIL rsp_data got=%h want=%h", s_data, e);
          end else
            $display("rsp beat data=%h ok", s_data);
        end
      end
      #1;
      if (resp_en && pend.size() > 0) begin
        p = pend.pop_front();
        ifc.tcdm_vld_i = 1'b1;
        ifc.tcdm_rdata_i = p.data;
      end else begin
        ifc.tcdm_vld_i = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // present one request to the main DUT and hold it until granted
  task automatic issue(input logic [31:0] a, input logic w);
    bit done = 1'b0;
    ifc.in_valid_i = 1'b1; ifc.in_addr_i = a; ifc.in_wen_i = w;
    ifc.in_wdata_i = ~a; ifc.in_be_i = a[5:2];
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (ifc.in_ready_o) begin
        vec_cnt++;
        if (ifc.tcdm_req_o !== 1'b1 || ifc.tcdm_add_o !== a || ifc.tcdm_wen_o !== w ||
            ifc.tcdm_wdata_o !== ~a || ifc.tcdm_be_o !== a[5:2]) begin
          err_cnt++;
          $display("FAIL passthrough got=%b/%h/%b want=1/%h/%b", ifc.tcdm_req_o, ifc.tcdm_add_o, ifc.tcdm_wen_o, a, w);
        end else
          $display("req addr=%h wen=%b granted", a, w);
        done = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid_i = 1'b0;
      end
    end
    if (!done) begin
      vec_cnt++; err_cnt++;
      $display("FAIL issue_timeout got=no_grant want=grant addr=%h", a);
      ifc.in_valid_i = 1'b0;
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && pend.size() == 0 && ifc.idle_o === 1'b1) done = 1'b1;
    end
    vec_cnt++;
    if (!done) begin
      err_cnt++;
      $display("FAIL drain got=exp%0d/idle%b want=exp0/idle1", exp_q.size(), ifc.idle_o);
    end
    sync();
  endtask

  task automatic test_reset();
    ifc.in_valid_i = 1'b1; ifc.in_wen_i = 1'b0; ifc.in_addr_i = 32'h0; ifc.tcdm_gnt_i = 1'b0;
    ifn.in_valid_i = 1'b1; ifn.in_wen_i = 1'b0; ifn.in_addr_i = 32'h0; ifn.tcdm_gnt_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (ifc.idle_o !== 1'b1 || ifc.rsp_valid_o !== 1'b0 || ifc.err_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_state got=idle%b/v%b/e%b want=1/0/0", ifc.idle_o, ifc.rsp_valid_o, ifc.err_o);
    end else $display("reset state ok");
    vec_cnt++;
    if (ifc.tcdm_req_o !== 1'b1 || ifc.in_ready_o !== 1'b0 || ifn.tcdm_req_o !== 1'b1) begin
      err_cnt++; $display("FAIL reset_req got=%b/%b/%b want=1/0/1", ifc.tcdm_req_o, ifc.in_ready_o, ifn.tcdm_req_o);
    end else $display("reset credit ok");
    sync();
    ifc.in_valid_i = 1'b0; ifc.tcdm_gnt_i = 1'b1;
    ifn.in_valid_i = 1'b0; ifn.tcdm_gnt_i = 1'b1;
    rst = 1'b0;
    sync();
  endtask

  task automatic test_single_load();
    ifc.rsp_ready_i = 1'b0;
    issue(32'h40, 1'b0);
    @(negedge clk);
    vec_cnt++;
    if (ifc.rsp_valid_o !== 1'b0 || ifc.idle_o !== 1'b0) begin
      err_cnt++; $display("FAIL single_lat1 got=v%b/idle%b want=0/0", ifc.rsp_valid_o, ifc.idle_o);
    end
    @(negedge clk);
    vec_cnt++;
    if (ifc.rsp_valid_o !== 1'b1 || ifc.rsp_rdata_o !== 32'hDEADBEEF) begin
      err_cnt++; $display("FAIL single_rsp got=%b/%h want=1/deadbeef", ifc.rsp_valid_o, ifc.rsp_rdata_o);
    end else $display("single load rsp=%h", ifc.rsp_rdata_o);
    sync();
    ifc.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (ifc.idle_o !== 1'b1 || ifc.rsp_valid_o !== 1'b0) begin
      err_cnt++; $display("FAIL single_idle got=idle%b/v%b want=1/0", ifc.idle_o, ifc.rsp_valid_o);
    end
    sync();
  endtask

  task automatic test_credit_stall();
    int g0 = grant_cnt;
    logic [31:0] hold;
    ifc.rsp_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) issue(32'h100 + 32'(i * 4), 1'b0);
      end
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (grant_cnt - g0 != 4 || ifc.tcdm_req_o !== 1'b0 || ifc.in_ready_o !== 1'b0) begin
          err_cnt++; $display("FAIL credit_stall got=%0d/req%b want=4/0", grant_cnt - g0, ifc.tcdm_req_o);
        end else $display("credit stall at %0d grants", grant_cnt - g0);
        vec_cnt++;
        hold = ifc.rsp_rdata_o;
        if (ifc.rsp_valid_o !== 1'b1 || hold !== mem_val(32'h100)) begin
          err_cnt++; $display("FAIL stall_head got=%b/%h want=1/%h", ifc.rsp_valid_o, hold, mem_val(32'h100));
        end
        @(negedge clk);
        vec_cnt++;
        if (ifc.rsp_rdata_o !== hold) begin
          err_cnt++; $display("FAIL stall_hold got=%h want=%h", ifc.rsp_rdata_o, hold);
        end
        sync();
        ifc.rsp_ready_i = 1'b1;
      end
    join
    wait_drain();
    vec_cnt++;
    if (grant_cnt - g0 != 6) begin
      err_cnt++; $display("FAIL credit_total got=%0d want=6", grant_cnt - g0);
    end
  endtask

  task automatic test_store_load_store();
    int r0 = rsp_cnt;
    ifc.rsp_ready_i = 1'b1;
    issue(32'h200, 1'b1);
    issue(32'h204, 1'b0);
    issue(32'h208, 1'b1);
    wait_drain();
    vec_cnt++;
    if (rsp_cnt - r0 != 1) begin
      err_cnt++; $display("FAIL sls_beats got=%0d want=1", rsp_cnt - r0);
    end else $display("store/load/store gave one beat");
  endtask

  task automatic test_untracked_stores();
    int n = 0;
    ifn.rsp_ready_i = 1'b0; ifn.tcdm_vld_i = 1'b0; ifn.tcdm_rdata_i = '0;
    ifn.in_wdata_i = '0; ifn.in_be_i = 4'hF;
    ifn.in_valid_i = 1'b1; ifn.in_wen_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifn.in_addr_i = 32'h500 + 32'(i * 4);
      @(negedge clk);
      vec_cnt++;
      if (ifn.tcdm_req_o !== 1'b1) begin
        err_cnt++; $display("FAIL nw_load%0d got=%b want=1", i, ifn.tcdm_req_o);
      end
      sync();
    end
    @(negedge clk);
    vec_cnt++;
    if (ifn.tcdm_req_o !== 1'b0 || ifn.in_ready_o !== 1'b0) begin
      err_cnt++; $display("FAIL nw_load_block got=%b/%b want=0/0", ifn.tcdm_req_o, ifn.in_ready_o);
    end
    sync();
    ifn.in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifn.tcdm_vld_i = 1'b1; ifn.tcdm_rdata_i = 32'hA000 + 32'(i);
      sync();
    end
    ifn.tcdm_vld_i = 1'b0;
    ifn.in_valid_i = 1'b1; ifn.in_wen_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifn.in_addr_i = 32'h600 + 32'(i * 4); ifn.in_wdata_i = 32'(i);
      @(negedge clk);
      if (ifn.tcdm_req_o === 1'b1 && ifn.in_ready_o === 1'b1) n++;
      sync();
    end
    ifn.in_valid_i = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (n != 8 || ifn.rsp_valid_o !== 1'b1 || ifn.rsp_rdata_o !== 32'hA000 || ifn.err_o !== 1'b0) begin
      err_cnt++; $display("FAIL nw_stores got=%0d/%b/%h want=8/1/0000a000", n, ifn.rsp_valid_o, ifn.rsp_rdata_o);
    end else $display("untracked stores granted=%0d", n);
    sync();
    ifn.rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (ifn.rsp_valid_o !== 1'b1 || ifn.rsp_rdata_o !== 32'hA000 + 32'(i)) begin
        err_cnt++; $display("FAIL nw_drain%0d got=%b/%h want=1/%h", i, ifn.rsp_valid_o, ifn.rsp_rdata_o, 32'hA000 + 32'(i));
      end
      sync();
    end
    ifn.rsp_ready_i = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (ifn.idle_o !== 1'b1 || ifn.rsp_valid_o !== 1'b0) begin
      err_cnt++; $display("FAIL nw_idle got=%b/%b want=1/0", ifn.idle_o, ifn.rsp_valid_o);
    end
    sync();
  endtask

  task automatic test_back_to_back();
    int c0 = cyc;
    int r0 = rsp_cnt;
    ifc.rsp_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) issue(32'h300 + 32'(i * 4), 1'b0);
    vec_cnt++;
    if (cyc - c0 != 16) begin
      err_cnt++; $display("FAIL b2b_rate got=%0d want=16", cyc - c0);
    end else $display("16 loads in %0d cycles", cyc - c0);
    @(negedge clk);
    vec_cnt++;
    if (ifc.rsp_valid_o !== 1'b1 || ifc.idle_o !== 1'b0) begin
      err_cnt++; $display("FAIL b2b_flow got=%b/%b want=1/0", ifc.rsp_valid_o, ifc.idle_o);
    end
    wait_drain();
    vec_cnt++;
    if (rsp_cnt - r0 != 16) begin
      err_cnt++; $display("FAIL b2b_beats got=%0d want=16", rsp_cnt - r0);
    end
  endtask

  task automatic test_spurious_vld();
    pend_t p;
    @(negedge clk);
    vec_cnt++;
    if (ifc.idle_o !== 1'b1 || ifc.err_o !== 1'b0) begin
      err_cnt++; $display("FAIL spur_pre got=%b/%b want=1/0", ifc.idle_o, ifc.err_o);
    end
    p.wen = 1'b1; p.data = 32'h0;
    pend.push_back(p);
    @(negedge clk);
    @(negedge clk);
    vec_cnt++;
    if (ifc.err_o !== 1'b1 || ifc.rsp_valid_o !== 1'b0 || ifc.idle_o !== 1'b1) begin
      err_cnt++; $display("FAIL spur_err got=e%b/v%b/i%b want=1/0/1", ifc.err_o, ifc.rsp_valid_o, ifc.idle_o);
    end else $display("spurious vld flagged");
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (ifc.err_o !== 1'b1) begin
      err_cnt++; $display("FAIL spur_sticky got=%b want=1", ifc.err_o);
    end
    sync();
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (ifc.err_o !== 1'b0 || ifc.idle_o !== 1'b1) begin
      err_cnt++; $display("FAIL spur_rst got=%b/%b want=0/1", ifc.err_o, ifc.idle_o);
    end
    sync();
    rst = 1'b0;
    sync();
  endtask

  task automatic test_reset_mid();
    ifc.rsp_ready_i = 1'b0;
    issue(32'h700, 1'b0);
    issue(32'h704, 1'b0);
    sync(); sync();
    resp_en = 1'b0;
    issue(32'h708, 1'b0);
    issue(32'h70C, 1'b0);
    @(negedge clk);
    vec_cnt++;
    if (ifc.rsp_valid_o !== 1'b1 || ifc.idle_o !== 1'b0) begin
      err_cnt++; $display("FAIL mid_busy got=%b/%b want=1/0", ifc.rsp_valid_o, ifc.idle_o);
    end
    sync();
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (ifc.rsp_valid_o !== 1'b0 || ifc.idle_o !== 1'b1) begin
      err_cnt++; $display("FAIL mid_rst got=%b/%b want=0/1", ifc.rsp_valid_o, ifc.idle_o);
    end else $display("mid-op reset dropped state");
    exp_q.delete();
    sync();
    rst = 1'b0;
    resp_en = 1'b1;
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (ifc.err_o !== 1'b1 || ifc.rsp_valid_o !== 1'b0 || ifc.idle_o !== 1'b1) begin
      err_cnt++; $display("FAIL mid_stale got=e%b/v%b/i%b want=1/0/1", ifc.err_o, ifc.rsp_valid_o, ifc.idle_o);
    end
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    sync();
  endtask

  initial begin
    ifc.in_valid_i = 1'b0; ifc.in_addr_i = '0; ifc.in_wen_i = 1'b0;
    ifc.in_wdata_i = '0; ifc.in_be_i = '0; ifc.rsp_ready_i = 1'b0; ifc.tcdm_gnt_i = 1'b0;
    ifn.in_valid_i = 1'b0; ifn.in_addr_i = '0; ifn.in_wen_i = 1'b0;
    ifn.in_wdata_i = '0; ifn.in_be_i = '0; ifn.rsp_ready_i = 1'b0; ifn.tcdm_gnt_i = 1'b0;
    ifn.tcdm_vld_i = 1'b0; ifn.tcdm_rdata_i = '0;
    test_reset();
    test_single_load();
    test_credit_stall();
    test_store_load_store();
    test_untracked_stores();
    test_back_to_back();
    test_spurious_vld();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
